// File: rtl/i2c_tgt_pkg.sv
// Shared state encoding, register map and read-mux helper for the I2C temperature target.
package i2c_tgt_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TEMP_W = 13;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 4;

  localparam logic [BYTE_W-1:0] REG_TEMP_MSB = 8'h00;
  localparam logic [BYTE_W-1:0] REG_TEMP_LSB = 8'h01;
  localparam logic [BYTE_W-1:0] REG_STATUS   = 8'h02;
  localparam logic [BYTE_W-1:0] REG_CONFIG   = 8'h03;
  localparam logic [BYTE_W-1:0] REG_ID       = 8'h0B;
  localparam logic [BYTE_W-1:0] ID_DEFAULT   = 8'hCB;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_ACK,
    WR_DATA,
    DATA_ACK,
    RD_DATA,
    RD_ACK
  } tgt_state_e;

  // Read value of the register selected by the pointer.
  function automatic logic [BYTE_W-1:0] reg_read(
    input logic [BYTE_W-1:0] ptr,
    input logic [TEMP_W-1:0] snap,
    input logic [BYTE_W-1:0] cfg,
    input logic [BYTE_W-1:0] id
  );
    logic [BYTE_W-1:0] val;
    case (ptr)
      REG_TEMP_MSB: val = snap[TEMP_W-1:5];
      REG_TEMP_LSB: val = {snap[4:0], 3'b000};
      REG_STATUS:   val = '0;
      REG_CONFIG:   val = cfg;
      REG_ID:       val = id;
      default:      val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA synchroniser with registered edge/START/STOP pulses.
// Define I2C_FILTER_EN to add a 3-sample agreement glitch filter after the synchroniser.
module i2c_bus_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_l;
  logic                   sda_l;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   sda_q;
  logic                   scl_rise_q;
  logic                   scl_fall_q;
  logic                   start_q;
  logic                   stop_q;

  // Idle bus is high, so sync flops reset high to avoid spurious edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_FILTER_EN
  logic [1:0] scl_h_q;
  logic [1:0] sda_h_q;
  logic       scl_f_q;
  logic       sda_f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s};
      sda_h_q <= {sda_h_q[0], sda_s};
      scl_f_q <= scl_l;
      sda_f_q <= sda_l;
    end
  end

  // Level follows the input only once three consecutive samples agree.
  always_comb begin
    scl_l = scl_f_q;
    sda_l = sda_f_q;
    if (scl_s == scl_h_q[0] && scl_s == scl_h_q[1]) scl_l = scl_s;
    if (sda_s == sda_h_q[0] && sda_s == sda_h_q[1]) sda_l = sda_s;
  end
`else
  assign scl_l = scl_s;
  assign sda_l = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_prev_q <= scl_l;
      sda_prev_q <= sda_l;
      sda_q      <= sda_l;
      scl_rise_q <= scl_l & ~scl_prev_q;
      scl_fall_q <= ~scl_l & scl_prev_q;
      start_q    <= scl_l & scl_prev_q & sda_prev_q & ~sda_l;
      stop_q     <= scl_l & scl_prev_q & ~sda_prev_q & sda_l;
    end
  end

  assign sda_o      = sda_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating an ADT7420 temperature sensor (temp, status, config, ID registers).
// Optional I2C_FILTER_EN macro enables the bus glitch filter in i2c_bus_cond.
module i2c_temp_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR    = 7'h4B,
  parameter logic [BYTE_W-1:0] ID_VAL      = ID_DEFAULT,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic [TEMP_W-1:0] temp_in,
  output logic [BYTE_W-1:0] cfg_out,
  output logic              busy,
  output logic              rd_strobe
);

  localparam logic [CNT_W-1:0] RX_DONE = CNT_W'(BYTE_W);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(BYTE_W - 1);

  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  logic [BYTE_W-1:0] rd_byte;

  tgt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic [BYTE_W-1:0] cfg_q, cfg_d;
  logic [TEMP_W-1:0] snap_q, snap_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              sda_oe_q, sda_oe_d;
  logic              rd_strobe_q, rd_strobe_d;

  i2c_bus_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_cond (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign rd_byte = reg_read(ptr_q, snap_q, cfg_q, ID_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= REG_TEMP_MSB;
      cfg_q       <= '0;
      snap_q      <= '0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      cfg_q       <= cfg_d;
      snap_q      <= snap_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  // Receive states shift on SCL rise; every SDA drive change happens on SCL fall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    cfg_d       = cfg_q;
    snap_d      = snap_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    rd_strobe_d = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ADDR, WR_PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[BYTE_W-2:0], sda_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (scl_fall && cnt_q == RX_DONE) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              if (shift_q[BYTE_W-1:1] == DEV_ADDR) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
                busy_d   = 1'b1;
                if (shift_q[0]) snap_d = temp_in;
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == WR_PTR) begin
              ptr_d    = shift_q;
              state_d  = WR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              if (ptr_q == REG_CONFIG) cfg_d = shift_q;
              ptr_d    = ptr_q + BYTE_W'(1);
              state_d  = DATA_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d  = RD_DATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[BYTE_W-1];
            end else begin
              state_d  = WR_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            state_d  = WR_DATA;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == TX_LAST) begin
              state_d  = RD_ACK;
              cnt_d    = '0;
              sda_oe_d = 1'b0;
            end else begin
              cnt_d    = cnt_q + CNT_W'(1);
              shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
              sda_oe_d = ~shift_q[BYTE_W-2];
            end
          end
        end
        RD_ACK: begin
          // cnt_q != 0 marks an ACK seen; the next byte is loaded on the following fall.
          if (scl_rise) begin
            ptr_d = ptr_q + BYTE_W'(1);
            if (sda_s) begin
              state_d = IDLE;
            end else begin
              rd_strobe_d = 1'b1;
              cnt_d       = CNT_W'(1);
            end
          end else if (scl_fall && cnt_q != '0) begin
            state_d  = RD_DATA;
            cnt_d    = '0;
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[BYTE_W-1];
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign cfg_out   = cfg_q;
  assign busy      = busy_q;
  assign rd_strobe = rd_strobe_q;

endmodule
